ifid_pipeline_reg: RTL and testbench
====================================

# ifid_pipeline_reg

IF/ID pipeline register with integrated load-use hazard detection and control-hazard flush, sitting directly downstream of the fetch stage and feeding the decode stage. Each cycle it captures the PC+4 value and the fetched instruction. It inserts a bubble and freezes the PC on a load-use hazard, and squashes the captured instruction when a branch or jump redirects fetch. Saturating stall/flush counters are exposed for debug and performance checks.

## Interface
- No parameters; all widths are fixed by the 32-bit MIPS datapath.
- Clk  in  1  pipeline clock, rising edge
- Rst  in  1  synchronous, active-high reset
- PCAdder_in  in  32  PC+4 from fetch
- Instr_in  in  32  instruction word from fetch
- Branch_in  in  1  branch taken (same signal that drives the fetch PCSrc mux)
- Jump_in  in  1  jump decoded (same signal that drives the fetch jump mux)
- IDEX_MemRead_in  in  1  instruction in EX is a load
- IDEX_Rt_in  in  5  destination register of the load in EX
- PCAdder_out  out  32  registered PC+4 to decode
- Instr_out  out  32  registered instruction to decode
- Valid_out  out  1  Instr_out is a live instruction, not a bubble or squash
- PCWrite_out  out  1  PC write enable to fetch; 0 freezes the PC
- Bubble_out  out  1  forces ID/EX control signals to zero this cycle
- StallCount_out  out  16  number of hazard-stall cycles, saturating
- FlushCount_out  out  16  number of flush cycles, saturating

## Operation
- Hazard (combinational) = Valid_out & IDEX_MemRead_in & (IDEX_Rt_in != 0) & ((IDEX_Rt_in == Instr_out[25:21]) | (IDEX_Rt_in == Instr_out[20:16])).
- Flush = Branch_in | Jump_in.
- PCWrite_out = ~Hazard | Flush. Bubble_out = Hazard & ~Flush.
- The register update on each rising Clk edge uses this priority:
  - Rst: PCAdder_out=0, Instr_out=32'h0 (NOP), Valid_out=0, StallCount_out=0, FlushCount_out=0.
  - Flush: Instr_out<=NOP, Valid_out<=0, PCAdder_out<=PCAdder_in; FlushCount increments.
  - Hazard: all pipeline fields hold their values; StallCount increments.
  - Otherwise: PCAdder_out<=PCAdder_in, Instr_out<=Instr_in, Valid_out<=1.
- Flush wins over a simultaneous hazard, because the stalled instruction is on a dead path. No stall is counted in that cycle.
- Counters saturate at 16'hFFFF and never wrap.
- A NOP or invalid slot never raises a hazard because Hazard is gated by Valid_out. A register field of $0 never matches because IDEX_Rt_in must be nonzero.

## Timing
- Capture latency: 1 cycle from fetch outputs to PCAdder_out and Instr_out.
- Hazard, PCWrite_out and Bubble_out are combinational from current state and inputs, so they are valid in the same cycle.
- A load-use pair stalls for exactly 1 cycle. In the next cycle the load has left EX, so IDEX_MemRead_in drops and Hazard clears.
- A flush takes effect at the next edge. Valid_out is 0 for exactly one cycle per flush cycle.
- Rst asserted mid-stall or mid-flush overrides everything at that edge. The cycle after reset shows Valid_out=0 and PCWrite_out=1.

## Structure
- Shared package holds:
  - NOP_INSTR = 32'h0000_0000
  - RS_MSB/RS_LSB = 25/21
  - RT_MSB/RT_LSB = 20/16
  - CNT_W = 16
- The natural sub-module is load_use_detect: a combinational unit from (Valid, MemRead, Rt, instr) to Hazard, reused later when forwarding is added.
- Counters stay inline in this block.

## Test plan
- Rst high for 2 edges, then release with Instr_in=32'h2008_0005 and PCAdder_in=4.
  - During reset: all outputs 0, PCWrite_out=1.
  - One edge after release: Instr_out=32'h2008_0005, PCAdder_out=4, Valid_out=1.
- Instr_out=lw-dependent add 32'h0109_5020 (rs=8), IDEX_MemRead_in=1, IDEX_Rt_in=8.
  - PCWrite_out=0 and Bubble_out=1.
  - Outputs hold for 1 edge and StallCount_out=1.
  - After MemRead drops, the next instruction loads.
- Same hazard with IDEX_Rt_in=0: no stall, PCWrite_out=1.
- Jump_in=1 with Instr_in=32'h1234_5678.
  - Next edge: Instr_out=0, Valid_out=0, FlushCount_out=1.
- Branch_in=1 while the hazard condition is true.
  - Flush wins: Instr_out=0, Valid_out=0, StallCount_out unchanged, PCWrite_out=1.
- Force a stall for 70000 consecutive cycles.
  - StallCount_out saturates at 16'hFFFF.
  - Rst then returns it to 0.

Source files
------------

// File: rtl/ifid_pipeline_reg_pkg.sv
// Shared constants and helpers for the IF/ID pipeline register and its hazard unit.
// Field positions follow the MIPS R-type/I-type encoding.
package ifid_pipeline_reg_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int CNT_W  = 16;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/ifid_pipeline_reg_load_use_detect.sv
// Load-use hazard detection: flags a decode-stage instruction that reads the
// register a load in EX is about to write.
module ifid_pipeline_reg_load_use_detect
    import ifid_pipeline_reg_pkg::*;
(
    input  logic        valid,
    input  logic        mem_read,
    input  logic [4:0]  rt,
    input  logic [31:0] instr,
    output logic        hazard
);

    logic [4:0] src_rs;
    logic [4:0] src_rt;
    logic       unused_instr_bits;

    assign src_rs = instr[RS_MSB:RS_LSB];
    assign src_rt = instr[RT_MSB:RT_LSB];
    assign unused_instr_bits = ^{instr[31:26], instr[15:0]};

    // $0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard = valid & mem_read & (rt != 5'd0) & ((rt == src_rs) | (rt == src_rt));

endmodule

// File: rtl/ifid_pipeline_reg.sv
// IF/ID pipeline register with load-use stall, branch/jump squash and
// saturating stall/flush debug counters.
module ifid_pipeline_reg
    import ifid_pipeline_reg_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      PCAdder_in,
    input  logic [31:0]      Instr_in,
    input  logic             Branch_in,
    input  logic             Jump_in,
    input  logic             IDEX_MemRead_in,
    input  logic [4:0]       IDEX_Rt_in,
    output logic [31:0]      PCAdder_out,
    output logic [31:0]      Instr_out,
    output logic             Valid_out,
    output logic             PCWrite_out,
    output logic             Bubble_out,
    output logic [CNT_W-1:0] StallCount_out,
    output logic [CNT_W-1:0] FlushCount_out
);

    logic hazard;
    logic flush;

    ifid_pipeline_reg_load_use_detect u_load_use_detect (
        .valid    (Valid_out),
        .mem_read (IDEX_MemRead_in),
        .rt       (IDEX_Rt_in),
        .instr    (Instr_out),
        .hazard   (hazard)
    );

    assign flush = Branch_in | Jump_in;

    // A redirect kills the stalled instruction, so the PC must move even under a hazard.
    assign PCWrite_out = ~hazard | flush;
    assign Bubble_out  = hazard & ~flush;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            PCAdder_out    <= 32'h0;
            Instr_out      <= NOP_INSTR;
            Valid_out      <= 1'b0;
            StallCount_out <= '0;
            FlushCount_out <= '0;
        end else if (flush) begin
            PCAdder_out    <= PCAdder_in;
            Instr_out      <= NOP_INSTR;
            Valid_out      <= 1'b0;
            FlushCount_out <= sat_inc(FlushCount_out);
        end else if (hazard) begin
            StallCount_out <= sat_inc(StallCount_out);
        end else begin
            PCAdder_out <= PCAdder_in;
            Instr_out   <= Instr_in;
            Valid_out   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifid_pipeline_reg.sv
// Directed bench for ifid_pipeline_reg: reset, capture, load-use stall,
// flush priority and counter saturation.
module tb_ifid_pipeline_reg;

    logic        Clk;
    logic        Rst;
    logic [31:0] PCAdder_in;
    logic [31:0] Instr_in;
    logic        Branch_in;
    logic        Jump_in;
    logic        IDEX_MemRead_in;
    logic [4:0]  IDEX_Rt_in;
    logic [31:0] PCAdder_out;
    logic [31:0] Instr_out;
    logic        Valid_out;
    logic        PCWrite_out;
    logic        Bubble_out;
    logic [15:0] StallCount_out;
    logic [15:0] FlushCount_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    ifid_pipeline_reg dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .PCAdder_in      (PCAdder_in),
        .Instr_in        (Instr_in),
        .Branch_in       (Branch_in),
        .Jump_in         (Jump_in),
        .IDEX_MemRead_in (IDEX_MemRead_in),
        .IDEX_Rt_in      (IDEX_Rt_in),
        .PCAdder_out     (PCAdder_out),
        .Instr_out       (Instr_out),
        .Valid_out       (Valid_out),
        .PCWrite_out     (PCWrite_out),
        .Bubble_out      (Bubble_out),
        .StallCount_out  (StallCount_out),
        .FlushCount_out  (FlushCount_out)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // checking
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Drive a fetch word and record what decode should see after the next edge.
    task automatic drive_fetch(input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] exp_instr);
        PCAdder_in = pc;
        Instr_in   = instr;
        exp_q.push_back(exp_instr);
    endtask

    task automatic check_capture(input string tag);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", tag, Instr_out);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, Instr_out, exp);
        end
    endtask

    initial begin
        Rst = 1'b1;
        PCAdder_in = 32'h0;
        Instr_in = 32'h0;
        Branch_in = 1'b0;
        Jump_in = 1'b0;
        IDEX_MemRead_in = 1'b0;
        IDEX_Rt_in = 5'd0;

        tick();
        tick();
        check_eq("rst_pc", PCAdder_out, 32'h0);
        check_eq("rst_instr", Instr_out, 32'h0);
        check_eq("rst_valid", {31'h0, Valid_out}, 32'h0);
        check_eq("rst_stall", {16'h0, StallCount_out}, 32'h0);
        check_eq("rst_flush", {16'h0, FlushCount_out}, 32'h0);
        check_eq("rst_pcwrite", {31'h0, PCWrite_out}, 32'h1);
        check_eq("rst_bubble", {31'h0, Bubble_out}, 32'h0);

        // First capture after release
        Rst = 1'b0;
        drive_fetch(32'd4, 32'h2008_0005, 32'h2008_0005);
        tick();
        check_capture("cap0_instr");
        check_eq("cap0_pc", PCAdder_out, 32'd4);
        check_eq("cap0_valid", {31'h0, Valid_out}, 32'h1);

        // Load-use on rs
        drive_fetch(32'd8, 32'h0109_5020, 32'h0109_5020);
        tick();
        check_capture("cap1_instr");
        IDEX_MemRead_in = 1'b1;
        IDEX_Rt_in = 5'd8;
        drive_fetch(32'd12, 32'h0128_5822, 32'h0109_5020);
        settle();
        check_eq("hz_pcwrite", {31'h0, PCWrite_out}, 32'h0);
        check_eq("hz_bubble", {31'h0, Bubble_out}, 32'h1);
        tick();
        check_capture("hz_hold_instr");
        check_eq("hz_hold_pc", PCAdder_out, 32'd8);
        check_eq("hz_hold_valid", {31'h0, Valid_out}, 32'h1);
        check_eq("hz_stall_cnt", {16'h0, StallCount_out}, 32'd1);
        IDEX_MemRead_in = 1'b0;
        settle();
        check_eq("hz_clear_pcwrite", {31'h0, PCWrite_out}, 32'h1);
        exp_q.push_back(32'h0128_5822);
        tick();
        check_capture("hz_resume_instr");
        check_eq("hz_resume_pc", PCAdder_out, 32'd12);

        // Instr_out = 0x01285822: rs=9, rt=8
        IDEX_MemRead_in = 1'b1;
        IDEX_Rt_in = 5'd0;
        settle();
        check_eq("rt0_pcwrite", {31'h0, PCWrite_out}, 32'h1);
        check_eq("rt0_bubble", {31'h0, Bubble_out}, 32'h0);
        IDEX_Rt_in = 5'd8;
        settle();
        check_eq("rtfield_pcwrite", {31'h0, PCWrite_out}, 32'h0);
        IDEX_Rt_in = 5'd5;
        settle();
        check_eq("nomatch_pcwrite", {31'h0, PCWrite_out}, 32'h1);
        IDEX_MemRead_in = 1'b0;

        // Jump squash
        Jump_in = 1'b1;
        drive_fetch(32'd16, 32'h1234_5678, 32'h0);
        tick();
        Jump_in = 1'b0;
        check_capture("jmp_instr");
        check_eq("jmp_valid", {31'h0, Valid_out}, 32'h0);
        check_eq("jmp_pc", PCAdder_out, 32'd16);
        check_eq("jmp_flush_cnt", {16'h0, FlushCount_out}, 32'd1);

        // Branch during a live hazard: flush wins
        drive_fetch(32'd20, 32'h0109_5020, 32'h0109_5020);
        tick();
        check_capture("br_setup_instr");
        IDEX_MemRead_in = 1'b1;
        IDEX_Rt_in = 5'd8;
        Branch_in = 1'b1;
        drive_fetch(32'd24, 32'hDEAD_BEEF, 32'h0);
        settle();
        check_eq("br_pcwrite", {31'h0, PCWrite_out}, 32'h1);
        check_eq("br_bubble", {31'h0, Bubble_out}, 32'h0);
        tick();
        Branch_in = 1'b0;
        IDEX_MemRead_in = 1'b0;
        check_capture("br_instr");
        check_eq("br_valid", {31'h0, Valid_out}, 32'h0);
        check_eq("br_stall_cnt", {16'h0, StallCount_out}, 32'd1);
        check_eq("br_flush_cnt", {16'h0, FlushCount_out}, 32'd2);

        // Long stall to saturate the stall counter
        drive_fetch(32'd28, 32'h0109_5020, 32'h0109_5020);
        tick();
        check_capture("sat_setup_instr");
        IDEX_MemRead_in = 1'b1;
        IDEX_Rt_in = 5'd8;
        Instr_in = 32'h0000_1111;
        repeat (70000) tick();
        check_eq("sat_stall_cnt", {16'h0, StallCount_out}, 32'h0000_FFFF);
        check_eq("sat_hold_instr", Instr_out, 32'h0109_5020);
        check_eq("sat_hold_pc", PCAdder_out, 32'd28);

        // Reset in the middle of a stall
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        settle();
        check_eq("rst2_stall", {16'h0, StallCount_out}, 32'h0);
        check_eq("rst2_flush", {16'h0, FlushCount_out}, 32'h0);
        check_eq("rst2_valid", {31'h0, Valid_out}, 32'h0);
        check_eq("rst2_instr", Instr_out, 32'h0);
        check_eq("rst2_pcwrite", {31'h0, PCWrite_out}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
